// File: rtl/fpu_bcd_to_binary.sv
// rtl/fpu_bcd_to_binary.sv - 18-digit packed BCD to 64-bit binary converter
// One digit per cycle, MSD first, through a shift-add multiply-by-10 accumulator.
module fpu_bcd_to_binary (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [79:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] binary_out,
  output logic        sign_out,
  output logic        zero,
  output logic        invalid
);

  localparam logic S_IDLE    = 1'b0;
  localparam logic S_CONVERT = 1'b1;
  localparam logic [4:0] LAST_DIGIT = 5'd17;

  logic        state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [71:0] shreg_q, shreg_d;
  logic [63:0] acc_q, acc_d;
  logic        sign_q, sign_d;
  logic        inv_q, inv_d;
  logic        done_q, done_d;
  logic [63:0] bin_q, bin_d;
  logic        sign_out_q, sign_out_d;
  logic        zero_q, zero_d;
  logic        invalid_q, invalid_d;

  logic [3:0]  digit;
  logic        digit_bad;
  logic [63:0] acc_next;
  logic        unused_pad_bits;

  // Bits 78:72 of the operand carry no information for the magnitude.
  assign unused_pad_bits = ^bcd_in[78:72];

  assign digit     = shreg_q[71:68];
  assign digit_bad = (digit > 4'd9);
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + {60'd0, digit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    sign_d     = sign_q;
    inv_d      = inv_q;
    done_d     = 1'b0;
    bin_d      = bin_q;
    sign_out_d = sign_out_q;
    zero_d     = zero_q;
    invalid_d  = invalid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = bcd_in[71:0];
          sign_d  = bcd_in[79];
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          inv_d   = 1'b0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        acc_d   = acc_next;
        shreg_d = shreg_q << 4;
        inv_d   = inv_q | digit_bad;
        cnt_d   = cnt_q + 5'd1;
        // Result registers only move on the completion edge.
        if (cnt_q == LAST_DIGIT) begin
          bin_d      = acc_next;
          zero_d     = (acc_next == 64'd0);
          sign_out_d = sign_q;
          invalid_d  = inv_q | digit_bad;
          done_d     = 1'b1;
          cnt_d      = 5'd0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      shreg_q    <= 72'd0;
      acc_q      <= 64'd0;
      sign_q     <= 1'b0;
      inv_q      <= 1'b0;
      done_q     <= 1'b0;
      bin_q      <= 64'd0;
      sign_out_q <= 1'b0;
      zero_q     <= 1'b1;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      sign_q     <= sign_d;
      inv_q      <= inv_d;
      done_q     <= done_d;
      bin_q      <= bin_d;
      sign_out_q <= sign_out_d;
      zero_q     <= zero_d;
      invalid_q  <= invalid_d;
    end
  end

  assign busy       = (state_q == S_CONVERT);
  assign done       = done_q;
  assign binary_out = bin_q;
  assign sign_out   = sign_out_q;
  assign zero       = zero_q;
  assign invalid    = invalid_q;

endmodule

// File: tb/tb_fpu_bcd_to_binary.sv
// tb/tb_fpu_bcd_to_binary.sv - scoreboard bench for fpu_bcd_to_binary
// Expected results come from a decimal reference model or directed constants.
module tb_fpu_bcd_to_binary;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [79:0] bcd_in = 80'd0;
  logic        busy, done, sign_out, zero, invalid;
  logic [63:0] binary_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] bin;
    logic        sign;
    logic        zero;
    logic        inv;
    int          due;
  } exp_t;

  exp_t sb[$];

  fpu_bcd_to_binary dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .binary_out(binary_out),
    .sign_out(sign_out), .zero(zero), .invalid(invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: value = sum(digit_i * 10^i), wrapped to 64 bits.
  function automatic void model(input logic [79:0] v, output logic [63:0] r, output logic inv);
    logic [3:0] d;
    r = 64'd0;
    inv = 1'b0;
    for (int i = 17; i >= 0; i--) begin
      d = v[i*4 +: 4];
      r = r * 64'd10 + 64'(d);
      if (d > 4'd9) inv = 1'b1;
    end
  endfunction

  task automatic issue(input logic [79:0] v, input logic [63:0] eb, input logic ei);
    exp_t e;
    start = 1'b1;
    bcd_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    bcd_in = {16'($urandom), $urandom, $urandom, $urandom};
    e.bin = eb; e.sign = v[79]; e.zero = (eb == 64'd0); e.inv = ei; e.due = cyc + 18;
    sb.push_back(e);
  endtask

  task automatic issue_model(input logic [79:0] v);
    logic [63:0] r;
    logic inv;
    model(v, r, inv);
    issue(v, r, inv);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_bin"}, binary_out, 64'd0);
    chk({tag, "_sign"}, 64'(sign_out), 64'd0);
    chk({tag, "_zero"}, 64'(zero), 64'd1);
    chk({tag, "_inv"}, 64'(invalid), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_busy_overlap", 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'(sb.size()));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("binary_out", binary_out, e.bin);
        chk("sign_out", 64'(sign_out), 64'(e.sign));
        chk("zero", 64'(zero), 64'(e.zero));
        chk("invalid", 64'(invalid), 64'(e.inv));
      end
    end
  end

  initial begin
    logic [79:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_done", 64'(done), 64'd0);

    issue(80'h123, 64'h7B, 1'b0);
    wait_idle();
    issue(80'h0, 64'h0, 1'b0);
    wait_idle();
    issue({1'b1, 79'h456}, 64'h1C8, 1'b0);
    wait_idle();
    issue(80'h00999999999999999999, 64'h0DE0B6B3A763FFFF, 1'b0);
    wait_idle();
    issue({8'hFF, 72'h456}, 64'h1C8, 1'b0);
    wait_idle();
    issue(80'h7F999999999999999999, 64'h0DE0B6B3A763FFFF, 1'b0);
    wait_idle();
    issue({1'b1, 79'h0}, 64'h0, 1'b0);
    wait_idle();
    issue(80'hA, 64'hA, 1'b1);
    wait_idle();
    issue(80'h1, 64'h1, 1'b0);
    drain();

    // start during busy is dropped; start in the done cycle is taken.
    issue(80'h123, 64'h7B, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bcd_in = 80'h789;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    chk("done_cycle_start", 64'(done), 64'd1);
    issue(80'h789, 64'h315, 1'b0);
    drain();

    // Reset at E9 of a conversion aborts it with no done.
    issue(80'h123, 64'h7B, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    reset = 1'b0;
    check_reset_outputs("midreset");
    repeat (30) @(posedge clk);
    #1;
    chk("post_reset_no_done", 64'(sb.size()), 64'd0);
    issue(80'h4321, 64'h10E1, 1'b0);
    drain();

    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 18; k++)
        v[k*4 +: 4] = (($urandom % 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
      v[79:72] = 8'($urandom);
      issue_model(v);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
